// File: rtl/hba_pkg.sv
// rtl/hba_pkg.sv - shared types, defaults and helpers for the HBA bus fabric
package hba_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        XFER    = 2'd2
    } hba_state_t;

    localparam logic [7:0] HBA_ERR_DATA = 8'hDE;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hba_if.sv
// rtl/hba_if.sv - master-side requests and shared bus of the HBA fabric
interface hba_if #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 16,
    parameter int DBUS_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12
);

    logic [NUM_MASTERS-1:0]            hba_mrequest;
    logic [NUM_MASTERS-1:0]            hba_mgrant;
    logic [NUM_MASTERS-1:0]            hba_select_master;
    logic [NUM_MASTERS-1:0]            hba_rnw_master;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] hba_abus_master;
    logic [NUM_MASTERS*DBUS_WIDTH-1:0] hba_dbus_master;
    logic [NUM_SLAVES-1:0]             hba_xferack_slave;
    logic [NUM_SLAVES*DBUS_WIDTH-1:0]  hba_dbus_slave;
    logic                              hba_select;
    logic                              hba_rnw;
    logic [ADDR_WIDTH-1:0]             hba_abus;
    logic [DBUS_WIDTH-1:0]             hba_dbus;
    logic                              hba_xferack;

    // The fabric drives the shared bus, so it takes the master view.
    modport master (
        input  hba_mrequest, hba_select_master, hba_rnw_master, hba_abus_master,
               hba_dbus_master, hba_xferack_slave, hba_dbus_slave,
        output hba_mgrant, hba_select, hba_rnw, hba_abus, hba_dbus, hba_xferack
    );

    modport slave (
        output hba_mrequest, hba_select_master, hba_rnw_master, hba_abus_master,
               hba_dbus_master, hba_xferack_slave, hba_dbus_slave,
        input  hba_mgrant, hba_select, hba_rnw, hba_abus, hba_dbus, hba_xferack
    );

endinterface

// File: rtl/hba_rr_arbiter.sv
// rtl/hba_rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
module hba_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int PTR_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant
);

    logic found;

    // Two ascending scans: indices at/after ptr first, then the wrapped part.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && request[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && request[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hba_interconnect.sv
// rtl/hba_interconnect.sv - HBA fabric: round-robin grant FSM, bus muxing, watchdog, error flags
module hba_interconnect
    import hba_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int NUM_SLAVES     = 16,
    parameter int DBUS_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 256,
    parameter logic [DBUS_WIDTH-1:0] ERR_DATA = DBUS_WIDTH'(HBA_ERR_DATA)
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset,
    hba_if.master                 bus,
    output logic                  bus_err,
    output logic                  multi_ack_err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [7:0]            err_count
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;

    hba_state_t             state, state_next;
    logic [NUM_MASTERS-1:0] grant, grant_next, arb_grant;
    logic [PTR_W-1:0]       ptr, ptr_next, granted_idx;
    logic                   sel_g, req_g, slave_ack, timeout_ack, multi_ack;
    logic [ADDR_WIDTH-1:0]  abus_mux;
    logic [DBUS_WIDTH-1:0]  dbus_mux, dbus_ret;
    logic [NUM_SLAVES-1:0]  acks;

    hba_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .PTR_W       (PTR_W)
    ) u_arb (
        .request (bus.hba_mrequest),
        .ptr     (ptr),
        .grant   (arb_grant)
    );

    always_comb begin
        granted_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) granted_idx = PTR_W'(i);
        end
    end

    assign sel_g = |(bus.hba_select_master & grant);
    assign req_g = |(bus.hba_mrequest & grant);

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (|bus.hba_mrequest) begin
                    grant_next = arb_grant;
                    state_next = GRANTED;
                end
            end
            GRANTED: begin
                // An ack landing in the first select cycle already completes the transfer.
                if (sel_g) begin
                    if (!bus.hba_xferack) state_next = XFER;
                end else if (!req_g) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = (granted_idx == PTR_W'(NUM_MASTERS - 1)) ? '0
                                                                         : granted_idx + PTR_W'(1);
                end
            end
            XFER: begin
                if (bus.hba_xferack) state_next = GRANTED;
            end
            default: state_next = IDLE;
        endcase
    end

    assign acks      = bus.hba_xferack_slave;
    assign multi_ack = |(acks & (acks - NUM_SLAVES'(1)));

    always_ff @(posedge hba_clk) begin
        if (!hba_reset) begin
            state         <= IDLE;
            grant         <= '0;
            ptr           <= '0;
            multi_ack_err <= 1'b0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            ptr           <= ptr_next;
            multi_ack_err <= multi_ack;
        end
    end

    always_comb begin
        abus_mux = '0;
        dbus_mux = '0;
        dbus_ret = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                abus_mux = abus_mux | bus.hba_abus_master[i*ADDR_WIDTH +: ADDR_WIDTH];
                dbus_mux = dbus_mux | bus.hba_dbus_master[i*DBUS_WIDTH +: DBUS_WIDTH];
            end
        end
        for (int j = 0; j < NUM_SLAVES; j++) begin
            dbus_ret = dbus_ret | bus.hba_dbus_slave[j*DBUS_WIDTH +: DBUS_WIDTH];
        end
    end

    assign slave_ack       = |acks;
    assign bus.hba_mgrant  = grant;
    assign bus.hba_select  = sel_g;
    assign bus.hba_rnw     = |(bus.hba_rnw_master & grant);
    assign bus.hba_abus    = abus_mux;
    assign bus.hba_xferack = slave_ack | timeout_ack;
    assign bus.hba_dbus    = dbus_mux | dbus_ret |
                             ((timeout_ack && bus.hba_rnw) ? ERR_DATA : '0);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int TIMER_W = clog2(TIMEOUT_CYCLES + 1);
            // Registered ack: arm one cycle early so it lands on select cycle TIMEOUT_CYCLES.
            localparam int FIRE_AT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;

            logic [TIMER_W-1:0] timer;
            logic               counting, fire;

            assign counting = bus.hba_select && !slave_ack && !timeout_ack;
            assign fire     = counting && (timer == TIMER_W'(FIRE_AT));

            always_ff @(posedge hba_clk) begin
                if (!hba_reset) begin
                    timer       <= '0;
                    timeout_ack <= 1'b0;
                    bus_err     <= 1'b0;
                    err_addr    <= '0;
                    err_count   <= '0;
                end else begin
                    timeout_ack <= fire;
                    bus_err     <= fire;
                    timer       <= counting ? timer + TIMER_W'(1) : '0;
                    if (fire) begin
                        err_addr <= bus.hba_abus;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end
                end
            end
        end else begin : g_no_wdog
            assign timeout_ack = 1'b0;
            assign bus_err     = 1'b0;
            assign err_addr    = '0;
            assign err_count   = '0;
        end
    endgenerate

endmodule

// File: tb/tb_hba_interconnect.sv
// tb/tb_hba_interconnect.sv - self-checking bench for hba_interconnect
module tb_hba_interconnect;

    localparam int NM = 4;
    localparam int NS = 16;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int T  = 16;

    logic           hba_clk = 1'b0;
    logic           hba_reset;
    logic           bus_err, multi_ack_err;
    logic [AW-1:0]  err_addr;
    logic [7:0]     err_count;

    int checks  = 0;
    int errors  = 0;
    int ptr_m   = 0;
    int exp_cnt = 0;

    hba_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .DBUS_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    hba_interconnect #(
        .NUM_MASTERS    (NM),
        .NUM_SLAVES     (NS),
        .DBUS_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (8'hDE)
    ) dut (
        .hba_clk       (hba_clk),
        .hba_reset     (hba_reset),
        .bus           (bus),
        .bus_err       (bus_err),
        .multi_ack_err (multi_ack_err),
        .err_addr      (err_addr),
        .err_count     (err_count)
    );

    always #5 hba_clk = ~hba_clk;

    typedef struct {
        logic [NM-1:0]    sel_m;
        logic [NM-1:0]    rnw_m;
        logic [NM*AW-1:0] abus_m;
        logic [NM*DW-1:0] dbus_m;
        logic [NS-1:0]    ack_s;
        logic [NS*DW-1:0] dbus_s;
        logic             e_sel;
        logic             e_rnw;
        logic [AW-1:0]    e_abus;
        logic [DW-1:0]    e_dbus;
        logic             e_ack;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hba_clk);
        #1;
    endtask

    task automatic set_master(input int m, input logic sel, input logic rnw,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [NM-1:0] mk;
        mk = 4'b0001 << m;
        bus.hba_select_master = sel ? (bus.hba_select_master | mk) : (bus.hba_select_master & ~mk);
        bus.hba_rnw_master    = rnw ? (bus.hba_rnw_master | mk) : (bus.hba_rnw_master & ~mk);
        bus.hba_abus_master   = (bus.hba_abus_master & ~(48'hFFF << (AW * m))) | ({36'd0, a} << (AW * m));
        bus.hba_dbus_master   = (bus.hba_dbus_master & ~(32'hFF << (DW * m))) | ({24'd0, d} << (DW * m));
    endtask

    task automatic set_slave(input int s, input logic ack, input logic [DW-1:0] d);
        logic [NS-1:0] mk;
        mk = 16'h0001 << s;
        bus.hba_xferack_slave = ack ? (bus.hba_xferack_slave | mk) : (bus.hba_xferack_slave & ~mk);
        bus.hba_dbus_slave    = (bus.hba_dbus_slave & ~(128'hFF << (DW * s))) | ({120'd0, d} << (DW * s));
    endtask

    task automatic clear_all_drive();
        bus.hba_select_master = '0;
        bus.hba_rnw_master    = '0;
        bus.hba_abus_master   = '0;
        bus.hba_dbus_master   = '0;
        bus.hba_xferack_slave = '0;
        bus.hba_dbus_slave    = '0;
    endtask

    function automatic int rr_pick(input logic [NM-1:0] req, input int p);
        for (int k = 0; k < NM; k++) begin
            if (((req >> ((p + k) % NM)) & 4'b0001) != 4'b0000) return (p + k) % NM;
        end
        return -1;
    endfunction

    task automatic acquire(input int m);
        int c;
        bus.hba_mrequest = bus.hba_mrequest | (4'b0001 << m);
        c = 0;
        do begin
            tick();
            c++;
        end while (bus.hba_mgrant == 4'b0000 && c < 8);
        chk("acquire_grant", bus.hba_mgrant, 4'b0001 << m);
    endtask

    task automatic drop_bus(input int m);
        set_master(m, 1'b0, 1'b0, '0, '0);
        bus.hba_mrequest = bus.hba_mrequest & ~(4'b0001 << m);
        tick();
        chk("release_grant", bus.hba_mgrant, 4'b0000);
        ptr_m = (m + 1) % NM;
    endtask

    // Drives select in the current cycle; the slave acks on select cycle 'delay' (>=2).
    task automatic do_xfer(input int m, input logic rnw, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int s, input logic [DW-1:0] rd,
                           input int delay);
        set_master(m, 1'b1, rnw, addr, rnw ? 8'h00 : wd);
        for (int c = 1; c < delay; c++) tick();
        set_slave(s, 1'b1, rnw ? rd : 8'h00);
        #1;
        chk("xfer_ack", bus.hba_xferack, 1'b1);
        chk("xfer_rnw", bus.hba_rnw, rnw);
        chk("xfer_abus", bus.hba_abus, addr);
        chk("xfer_dbus", bus.hba_dbus, rnw ? rd : wd);
        tick();
        set_slave(s, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [NM-1:0] pending;
        logic [AW-1:0] addr;
        int            exp_m, c, rounds_rr;
        logic          rnw;

        vecs[0] = '{4'b1111, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111}, {8'h44, 8'h33, 8'h22, 8'h11},
                    16'h0000, 128'h0, 1'b1, 1'b1, 12'h333, 8'h33, 1'b0};
        vecs[1] = '{4'b1011, 4'b1011, {12'hFFF, 12'h000, 12'hFFF, 12'hFFF}, {8'hFF, 8'h00, 8'hFF, 8'hFF},
                    16'h0000, 128'h0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0};
        vecs[2] = '{4'b0100, 4'b0000, {12'h000, 12'h105, 24'h0}, {8'h00, 8'hA5, 16'h0},
                    16'h0000, 128'h0, 1'b1, 1'b0, 12'h105, 8'hA5, 1'b0};
        vecs[3] = '{4'b0100, 4'b0100, {12'h000, 12'h7C0, 24'h0}, 32'h0,
                    16'h0020, 128'h3C << 40, 1'b1, 1'b1, 12'h7C0, 8'h3C, 1'b1};
        vecs[4] = '{4'b0100, 4'b0100, {12'h000, 12'h123, 24'h0}, 32'h0,
                    16'h000C, (128'h0F << 16) | (128'hF0 << 24), 1'b1, 1'b1, 12'h123, 8'hFF, 1'b1};
        vecs[5] = '{4'b0000, 4'b0000, 48'h0, 32'h0,
                    16'h8000, 128'h81 << 120, 1'b0, 1'b0, 12'h000, 8'h81, 1'b1};

        hba_reset        = 1'b0;
        bus.hba_mrequest = '0;
        clear_all_drive();
        tick();
        tick();
        chk("rst_grant", bus.hba_mgrant, 4'b0000);
        chk("rst_select", bus.hba_select, 1'b0);
        chk("rst_abus", bus.hba_abus, 12'h000);
        chk("rst_dbus", bus.hba_dbus, 8'h00);
        chk("rst_xferack", bus.hba_xferack, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_multi", multi_ack_err, 1'b0);
        chk("rst_err_addr", err_addr, 12'h000);
        chk("rst_err_count", err_count, 8'h00);
        hba_reset = 1'b1;

        // Master 0 alone: grant one cycle after request, read of 0x105 answered by slave 1.
        bus.hba_mrequest = 4'b0001;
        tick();
        chk("t1_grant", bus.hba_mgrant, 4'b0001);
        do_xfer(0, 1'b1, 12'h105, 8'h00, 1, 8'h5A, 2);
        drop_bus(0);

        // Round-robin: six fixed rounds with masters 0,1,2 always requesting, then random.
        pending   = '0;
        rounds_rr = 0;
        for (int r = 0; r < 36; r++) begin
            if (r < 6) begin
                pending = 4'b0111;
            end else begin
                pending = pending | 4'($urandom_range(0, 15));
                if (pending == 4'b0000) pending = 4'b0001 << $urandom_range(0, 3);
            end
            bus.hba_mrequest = pending;
            exp_m = rr_pick(pending, ptr_m);
            c = 0;
            do begin
                tick();
                c++;
            end while (bus.hba_mgrant == 4'b0000 && c < 8);
            chk("rr_grant", bus.hba_mgrant, 4'b0001 << exp_m);
            if (bus.hba_mgrant == (4'b0001 << exp_m)) begin
                rnw = 1'($urandom_range(0, 1));
                do_xfer(exp_m, rnw, 12'($urandom), 8'($urandom), $urandom_range(0, NS - 1),
                        8'($urandom), $urandom_range(2, 5));
                drop_bus(exp_m);
                pending = pending & ~(4'b0001 << exp_m);
                rounds_rr++;
            end else begin
                pending          = '0;
                bus.hba_mrequest = '0;
                clear_all_drive();
                hba_reset = 1'b0;
                tick();
                hba_reset = 1'b1;
                ptr_m     = 0;
            end
        end
        chk("rr_rounds", rounds_rr, 36);
        bus.hba_mrequest = '0;
        tick();

        // Combinational mux/return table, each vector held only mid-cycle under master 2's grant.
        acquire(2);
        for (int i = 0; i < 6; i++) begin
            bus.hba_select_master = vecs[i].sel_m;
            bus.hba_rnw_master    = vecs[i].rnw_m;
            bus.hba_abus_master   = vecs[i].abus_m;
            bus.hba_dbus_master   = vecs[i].dbus_m;
            bus.hba_xferack_slave = vecs[i].ack_s;
            bus.hba_dbus_slave    = vecs[i].dbus_s;
            #2;
            chk("tbl_select", bus.hba_select, vecs[i].e_sel);
            chk("tbl_rnw", bus.hba_rnw, vecs[i].e_rnw);
            chk("tbl_abus", bus.hba_abus, vecs[i].e_abus);
            chk("tbl_dbus", bus.hba_dbus, vecs[i].e_dbus);
            chk("tbl_xferack", bus.hba_xferack, vecs[i].e_ack);
            clear_all_drive();
            tick();
        end
        drop_bus(2);

        // Read to an empty slot times out on select cycle T.
        acquire(0);
        set_master(0, 1'b1, 1'b1, 12'h900, 8'h00);
        for (int k = 1; k <= T; k++) begin
            if (k > 1) tick();
            else #1;
            chk("to_xferack", bus.hba_xferack, k == T);
            chk("to_bus_err", bus_err, k == T);
        end
        exp_cnt++;
        chk("to_dbus", bus.hba_dbus, 8'hDE);
        chk("to_err_addr", err_addr, 12'h900);
        chk("to_err_count", err_count, exp_cnt);
        tick();
        chk("to_bus_err_pulse", bus_err, 1'b0);
        chk("to_xferack_pulse", bus.hba_xferack, 1'b0);
        drop_bus(0);

        // Slave ack on cycle T-1 beats the watchdog.
        acquire(0);
        set_master(0, 1'b1, 1'b1, 12'h900, 8'h00);
        for (int k = 1; k < T - 1; k++) begin
            if (k > 1) tick();
            else #1;
            chk("late_noack", bus.hba_xferack, 1'b0);
        end
        tick();
        set_slave(4, 1'b1, 8'h77);
        #1;
        chk("late_xferack", bus.hba_xferack, 1'b1);
        chk("late_dbus", bus.hba_dbus, 8'h77);
        tick();
        set_slave(4, 1'b0, 8'h00);
        set_master(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("late_bus_err", bus_err, 1'b0);
        chk("late_xferack_off", bus.hba_xferack, 1'b0);
        chk("late_err_count", err_count, exp_cnt);
        drop_bus(0);
        chk("late_bus_err2", bus_err, 1'b0);

        // Two slaves ack together while an ungranted master drives junk.
        acquire(1);
        set_master(3, 1'b1, 1'b1, 12'hFFF, 8'hFF);
        set_master(1, 1'b1, 1'b0, 12'h0AB, 8'h11);
        #1;
        chk("ma_abus", bus.hba_abus, 12'h0AB);
        chk("ma_rnw", bus.hba_rnw, 1'b0);
        chk("ma_dbus", bus.hba_dbus, 8'h11);
        tick();
        set_slave(2, 1'b1, 8'h00);
        set_slave(3, 1'b1, 8'h00);
        #1;
        chk("ma_xferack", bus.hba_xferack, 1'b1);
        chk("ma_multi_early", multi_ack_err, 1'b0);
        tick();
        set_slave(2, 1'b0, 8'h00);
        set_slave(3, 1'b0, 8'h00);
        set_master(3, 1'b0, 1'b0, '0, '0);
        chk("ma_multi", multi_ack_err, 1'b1);
        drop_bus(1);
        chk("ma_multi_pulse", multi_ack_err, 1'b0);

        // Reset during XFER drops the grant on that edge.
        acquire(2);
        set_master(2, 1'b1, 1'b1, 12'h456, 8'h00);
        tick();
        hba_reset = 1'b0;
        tick();
        chk("rx_grant", bus.hba_mgrant, 4'b0000);
        chk("rx_select", bus.hba_select, 1'b0);
        chk("rx_abus", bus.hba_abus, 12'h000);
        chk("rx_dbus", bus.hba_dbus, 8'h00);
        chk("rx_err_count", err_count, 8'h00);
        hba_reset        = 1'b1;
        bus.hba_mrequest = '0;
        clear_all_drive();
        ptr_m   = 0;
        exp_cnt = 0;
        tick();

        // 300 back-to-back timeouts under one grant: err_count saturates.
        acquire(0);
        addr = '0;
        for (int i = 0; i < 300; i++) begin
            addr = 12'h900 | 12'(i & 8'hFF);
            set_master(0, 1'b1, 1'b1, addr, 8'h00);
            #1;
            c = 1;
            while (!bus.hba_xferack && c < 40) begin
                tick();
                c++;
            end
            chk("sat_latency", c, T);
            if (exp_cnt < 255) exp_cnt++;
            tick();
            set_master(0, 1'b0, 1'b0, '0, '0);
            tick();
        end
        chk("sat_err_count", err_count, exp_cnt);
        chk("sat_err_addr", err_addr, addr);
        drop_bus(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
